// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter: the bus owner states
// and the default bus widths.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;

endpackage

// File: rtl/wb_watchdog.sv
// Transfer watchdog: counts owner strobe cycles that have no termination and
// pulses timeout_o on the TIMEOUT_CYCLES-th such cycle.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic term_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // The first waiting cycle sees count 0, so the last allowed wait cycle sees T-1.
  assign timeout_o = en_i && !term_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || term_i || timeout_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 classic arbiter: round-robin per cyc burst, no preemption.
// Define WB_ARBITER2_TIMEOUT_EN to add the hung-transfer watchdog (err on timeout).
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [1:0]              gnt_o
);

  owner_e state_q, state_d;
  logic   last_q, last_d;
  logic   own0, own1;
  logic   timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Every handover passes through IDLE, which guarantees one dead bus cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      OWN1: if (!m1_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign own0  = (state_q == OWN0);
  assign own1  = (state_q == OWN1);
  assign gnt_o = {own1, own0};

`ifdef WB_ARBITER2_TIMEOUT_EN
  logic owner_stb;
  assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (owner_stb),
    .term_i   (s_ack_i | s_err_i | s_rty_i),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i & ~timeout;
      s_stb_o  = m0_stb_i & ~timeout;
      s_we_o   = m0_we_i;
      s_adr_o  = m0_adr_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i | timeout;
      m0_rty_o = s_rty_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i & ~timeout;
      s_stb_o  = m1_stb_i & ~timeout;
      s_we_o   = m1_we_i;
      s_adr_o  = m1_adr_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i | timeout;
      m1_rty_o = s_rty_i;
    end
    if (own0 || own1) begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus randomized traffic checked
// against an ownership/watchdog reference model.
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_dat_i, m0_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_dat_i, m1_dat_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    gnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter2 #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i   (clk_i),    .rst_ni  (rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i (m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i (m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),  .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),  .s_sel_o (s_sel_o),  .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),  .s_ack_i (s_ack_i),  .s_err_i (s_err_i),  .s_rty_i (s_rty_i),
    .gnt_o   (gnt_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_dat_i  = '0; s_ack_i  = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chkw({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    chk1({tag, "_scyc"}, s_cyc_o, 1'b0);
    chk1({tag, "_sstb"}, s_stb_o, 1'b0);
    chk1({tag, "_swe"}, s_we_o, 1'b0);
    chkw({tag, "_sadr"}, s_adr_o, 32'd0);
    chkw({tag, "_ssel"}, 32'(s_sel_o), 32'd0);
    chkw({tag, "_sdat"}, s_dat_o, 32'd0);
    chkw({tag, "_m0dat"}, m0_dat_o, 32'd0);
    chkw({tag, "_m1dat"}, m1_dat_o, 32'd0);
    chk1({tag, "_m0term"}, m0_ack_o | m0_err_o | m0_rty_o, 1'b0);
    chk1({tag, "_m1term"}, m1_ack_o | m1_err_o | m1_rty_o, 1'b0);
  endtask

  // Reset with busy-looking inputs so that zero outputs actually mean something.
  task automatic do_reset();
    @(negedge clk_i);
    rst_ni   = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m0_adr_i = 32'h1234_5678; s_ack_i = 1'b1; s_dat_i = 32'hA5A5_A5A5;
    #1 check_all_zero("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1'b1;
  endtask

  // Reference model state: owner is -1 when the bus is free.
  int            own, lst, wd;
  logic          ec, es, ew, term, to;
  logic [AW-1:0] ea;
  logic [SW-1:0] esel;
  logic [DW-1:0] ed;

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    do_reset();

    // Single m0 read, slave acks on the third owned cycle.
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1000_0000; m0_sel_i = 4'hF;
    #1 chkw("rd_gnt_lat", 32'(gnt_o), 32'd0);
    chk1("rd_scyc_lat", s_cyc_o, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      if (n == 2) begin s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; end
      #1 chkw("rd_gnt", 32'(gnt_o), 32'd1);
      chk1("rd_scyc", s_cyc_o, 1'b1);
      chkw("rd_sadr", s_adr_o, 32'h1000_0000);
      chk1("rd_m0ack", m0_ack_o, n == 2);
      chk1("rd_m1ack", m1_ack_o, 1'b0);
    end
    chkw("rd_m0dat", m0_dat_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    clear_inputs();

    // Simultaneous requests after reset: m0, idle gap, m1, idle gap, m0.
    do_reset();
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    @(negedge clk_i);
    #1 chkw("alt_first", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    m0_cyc_i = 1'b0;
    #1 chk1("alt_drop_scyc", s_cyc_o, 1'b0);
    @(negedge clk_i);
    #1 chkw("alt_gap1", 32'(gnt_o), 32'd0);
    chk1("alt_gap1_scyc", s_cyc_o, 1'b0);
    @(negedge clk_i);
    #1 chkw("alt_second", 32'(gnt_o), 32'd2);
    chk1("alt_second_scyc", s_cyc_o, 1'b1);
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b0;
    @(negedge clk_i);
    #1 chkw("alt_gap2", 32'(gnt_o), 32'd0);
    @(negedge clk_i);
    #1 chkw("alt_third", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    clear_inputs();

    // m1 burst of four writes while m0 keeps requesting.
    do_reset();
    @(negedge clk_i);
    m1_cyc_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h2000_0010; m1_sel_i = 4'b0011;
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h3000_0000;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      m1_stb_i = 1'b1; m1_dat_i = 32'h0000_0100 + 32'(n); s_ack_i = 1'b1;
      #1 chkw("bw_gnt", 32'(gnt_o), 32'd2);
      chk1("bw_swe", s_we_o, 1'b1);
      chkw("bw_ssel", 32'(s_sel_o), 32'h3);
      chkw("bw_sadr", s_adr_o, 32'h2000_0010);
      chkw("bw_sdat", s_dat_o, 32'h0000_0100 + 32'(n));
      chk1("bw_m1ack", m1_ack_o, 1'b1);
      chk1("bw_m0ack", m0_ack_o, 1'b0);
    end
    @(negedge clk_i);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    #1 chkw("bw_drop_gnt", 32'(gnt_o), 32'd2);
    @(negedge clk_i);
    #1 chkw("bw_gap", 32'(gnt_o), 32'd0);
    @(negedge clk_i);
    #1 chkw("bw_m0_after", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    clear_inputs();

    // Slave never terminates.
    do_reset();
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
`ifdef WB_ARBITER2_TIMEOUT_EN
    for (int n = 1; n <= TO + 1; n++) begin
      @(negedge clk_i);
      #1 chk1("wd_err", m0_err_o, n == TO);
      chk1("wd_sstb", s_stb_o, n != TO);
      chk1("wd_scyc", s_cyc_o, n != TO);
      chkw("wd_gnt", 32'(gnt_o), 32'd1);
    end
`else
    for (int n = 1; n <= TO + 4; n++) begin
      @(negedge clk_i);
      #1 chk1("hang_err", m0_err_o, 1'b0);
      chk1("hang_sstb", s_stb_o, 1'b1);
    end
`endif
    @(negedge clk_i);
    clear_inputs();

    // Reset asserted mid-transfer, while the slave is acking.
    do_reset();
    @(negedge clk_i);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h4000_0004;
    @(negedge clk_i);
    s_ack_i = 1'b1; s_dat_i = 32'h0BAD_F00D;
    #1 chk1("mid_scyc_before", s_cyc_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1'b1;
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    @(negedge clk_i);
    #1 chkw("mid_next_gnt", 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    clear_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    own = -1; lst = 1; wd = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      m0_cyc_i = m0_cyc_i ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
      m1_cyc_i = m1_cyc_i ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
      m0_stb_i = 1'($urandom_range(1)); m0_we_i = 1'($urandom_range(1));
      m1_stb_i = 1'($urandom_range(1)); m1_we_i = 1'($urandom_range(1));
      m0_adr_i = $urandom(); m0_sel_i = SW'($urandom()); m0_dat_i = $urandom();
      m1_adr_i = $urandom(); m1_sel_i = SW'($urandom()); m1_dat_i = $urandom();
      s_dat_i  = $urandom();
      s_ack_i  = ($urandom_range(2) == 0);
      s_err_i  = ($urandom_range(15) == 0);
      s_rty_i  = ($urandom_range(15) == 0);
      #1;
      {ec, es, ew, ea, esel, ed} = '0;
      if (own == 0) {ec, es, ew, ea, esel, ed} = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i};
      if (own == 1) {ec, es, ew, ea, esel, ed} = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};
      term = s_ack_i | s_err_i | s_rty_i;
      to   = 1'b0;
`ifdef WB_ARBITER2_TIMEOUT_EN
      to = (own >= 0) && es && !term && (wd == TO - 1);
`endif
      chkw("rnd_gnt", 32'(gnt_o), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
      chk1("rnd_scyc", s_cyc_o, ec & ~to);
      chk1("rnd_sstb", s_stb_o, es & ~to);
      chk1("rnd_swe", s_we_o, ew);
      chkw("rnd_sadr", s_adr_o, ea);
      chkw("rnd_ssel", 32'(s_sel_o), 32'(esel));
      chkw("rnd_sdat", s_dat_o, ed);
      chk1("rnd_m0ack", m0_ack_o, (own == 0) && s_ack_i);
      chk1("rnd_m1ack", m1_ack_o, (own == 1) && s_ack_i);
      chk1("rnd_m0err", m0_err_o, (own == 0) && (s_err_i || to));
      chk1("rnd_m1err", m1_err_o, (own == 1) && (s_err_i || to));
      chk1("rnd_m0rty", m0_rty_o, (own == 0) && s_rty_i);
      chk1("rnd_m1rty", m1_rty_o, (own == 1) && s_rty_i);
      chkw("rnd_m0dat", m0_dat_o, (own >= 0) ? s_dat_i : 32'd0);
      chkw("rnd_m1dat", m1_dat_o, (own >= 0) ? s_dat_i : 32'd0);
      @(posedge clk_i);
      wd = ((own >= 0) && es && !term && !to) ? wd + 1 : 0;
      if (own < 0) begin
        if (m0_cyc_i && m1_cyc_i) own = 1 - lst;
        else if (m0_cyc_i)        own = 0;
        else if (m1_cyc_i)        own = 1;
      end else if (!ec) begin
        lst = own;
        own = -1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
